// File: rtl/argmax_classifier.sv
// Argmax sink for the dense layer's score stream: collects OUT_COUNT signed
// scores, then reports the index and value of the largest with a done pulse.
module argmax_classifier #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 8,
  localparam int CW = $clog2(OUT_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] dataIn,
  input  logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        classIdx,
  output logic [DATA_SIZE-1:0] maxVal,
  output logic [CW-1:0]        sampleCnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  localparam logic [CW-1:0] LAST = CW'(OUT_COUNT - 1);

  state_t               state, state_n;
  logic [CW-1:0]        count, count_n;
  logic [DATA_SIZE-1:0] best, best_n;
  logic [CW-1:0]        best_idx, best_idx_n;
  logic [CW-1:0]        class_n;
  logic [DATA_SIZE-1:0] max_n;
  logic                 greater;

  assign greater = $signed(dataIn) > $signed(best);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      best     <= '0;
      best_idx <= '0;
      classIdx <= '0;
      maxVal   <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      best     <= best_n;
      best_idx <= best_idx_n;
      classIdx <= class_n;
      maxVal   <= max_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    best_n     = best;
    best_idx_n = best_idx;
    class_n    = classIdx;
    max_n      = maxVal;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE, REPORT: begin
          state_n = IDLE;
          // A sample arriving during REPORT is index 0 of the next burst
          if (valid) begin
            best_n     = dataIn;
            best_idx_n = '0;
            count_n    = CW'(1);
            state_n    = COLLECT;
          end
        end
        COLLECT: begin
          if (valid) begin
            if (greater) begin
              best_n     = dataIn;
              best_idx_n = count;
            end
            if (count == LAST) begin
              // Result includes this final sample, so take it from the compare
              class_n = greater ? count  : best_idx;
              max_n   = greater ? dataIn : best;
              count_n = '0;
              state_n = REPORT;
            end else begin
              count_n = count + CW'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  assign busy      = (state == COLLECT);
  assign done      = (state == REPORT);
  assign sampleCnt = (state == COLLECT) ? count : '0;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed bursts push expected
// (index, value) pairs; per-instance monitors pop them on each done pulse.
module tb_argmax_classifier;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] dataIn = '0;
  logic       valid = 1'b0;
  logic       busy, done;
  logic [1:0] classIdx, sampleCnt;
  logic [7:0] maxVal;

  logic [7:0] dataIn2 = '0;
  logic       valid2 = 1'b0;
  logic       busy2, done2;
  logic [3:0] classIdx2, sampleCnt2;
  logic [7:0] maxVal2;

  int n_vec  = 0;
  int n_miss = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  argmax_classifier #(.OUT_COUNT(3), .DATA_SIZE(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .dataIn(dataIn), .valid(valid),
    .busy(busy), .done(done), .classIdx(classIdx), .maxVal(maxVal),
    .sampleCnt(sampleCnt)
  );

  argmax_classifier #(.OUT_COUNT(10), .DATA_SIZE(8)) dut10 (
    .clk(clk), .rst(rst), .clear(clear), .dataIn(dataIn2), .valid(valid2),
    .busy(busy2), .done(done2), .classIdx(classIdx2), .maxVal(maxVal2),
    .sampleCnt(sampleCnt2)
  );

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_vec++;
      if (q1.size() == 0) begin
        n_miss++;
        $display("FAIL done3_unexpected: got done with classIdx=%0d maxVal=%02h, none expected",
                 classIdx, maxVal);
      end else begin
        e = q1.pop_front();
        if ({2'b00, classIdx} !== e.idx || maxVal !== e.val) begin
          n_miss++;
          $display("FAIL result3: got (%0d,%02h) expected (%0d,%02h)",
                   classIdx, maxVal, e.idx, e.val);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      exp_t e;
      n_vec++;
      if (q2.size() == 0) begin
        n_miss++;
        $display("FAIL done10_unexpected: got done with classIdx=%0d maxVal=%02h, none expected",
                 classIdx2, maxVal2);
      end else begin
        e = q2.pop_front();
        if (classIdx2 !== e.idx || maxVal2 !== e.val) begin
          n_miss++;
          $display("FAIL result10: got (%0d,%02h) expected (%0d,%02h)",
                   classIdx2, maxVal2, e.idx, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid  = v;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic [7:0] d);
    valid2  = v;
    dataIn2 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input logic [3:0] idx, input logic [7:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    q1.push_back(e);
  endtask

  task automatic expect10(input logic [3:0] idx, input logic [7:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    q2.push_back(e);
  endtask

  logic [7:0] burst_a [10] = '{8'h10, 8'hE0, 8'h25, 8'h31, 8'h07,
                               8'h31, 8'h80, 8'h2C, 8'h00, 8'h30};
  logic [7:0] burst_b [10] = '{8'h90, 8'h85, 8'hFF, 8'hC0, 8'hFE,
                               8'hFF, 8'h81, 8'hA0, 8'hB0, 8'hF0};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_classIdx", classIdx, 0);
    check("rst_maxVal", maxVal, 0);
    check("rst_sampleCnt", sampleCnt, 0);
    rst = 1'b0;
    step(0, 8'h00);

    // Basic burst with busy/sampleCnt tracking
    step(1, 8'h05);
    check("b1_busy", busy, 1);
    check("b1_cnt", sampleCnt, 1);
    step(1, 8'h7F);
    check("b2_busy", busy, 1);
    check("b2_cnt", sampleCnt, 2);
    expect3(1, 8'h7F);
    step(1, 8'h10);
    check("b3_busy", busy, 0);
    check("b3_done", done, 1);
    check("b3_cnt", sampleCnt, 0);
    step(0, 8'h00);
    check("b4_done_pulse", done, 0);

    // Signed compare and tie handling
    step(1, 8'h80); step(1, 8'hFF); expect3(1, 8'hFF); step(1, 8'hFE);
    step(0, 8'h00);
    step(1, 8'h20); step(1, 8'h20); expect3(0, 8'h20); step(1, 8'h10);
    step(0, 8'h00);

    // Gaps in valid
    step(1, 8'h01); step(0, 8'hAA); step(0, 8'hBB);
    step(1, 8'h09); step(0, 8'hCC);
    check("gap_busy", busy, 1);
    check("gap_cnt", sampleCnt, 2);
    expect3(1, 8'h09);
    step(1, 8'h03);
    step(0, 8'h00);

    // Six back-to-back valids form two bursts
    step(1, 8'h01); step(1, 8'h02); expect3(2, 8'h03); step(1, 8'h03);
    step(1, 8'h30); step(1, 8'h20); expect3(0, 8'h30); step(1, 8'h10);
    step(0, 8'h00);
    step(0, 8'h00);

    // Clear aborts a partial burst and drops a coincident valid
    step(1, 8'h40); step(1, 8'h50);
    clear = 1'b1;
    step(1, 8'h77);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_cnt", sampleCnt, 0);
    check("clr_classIdx", classIdx, 0);
    check("clr_maxVal", maxVal, 8'h30);
    step(0, 8'h00);
    check("clr_no_done", done, 0);
    step(1, 8'h00); step(1, 8'h01); expect3(2, 8'h02); step(1, 8'h02);
    step(0, 8'h00);

    // Async reset mid-burst
    step(1, 8'h11);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cnt", sampleCnt, 0);
    check("arst_classIdx", classIdx, 0);
    check("arst_maxVal", maxVal, 0);
    check("arst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 8'h00);
    step(1, 8'h03); step(1, 8'h0A); expect3(1, 8'h0A); step(1, 8'h05);
    step(0, 8'h00);

    // Ten-class configuration
    for (int i = 0; i < 10; i++) begin
      if (i == 9) expect10(3, 8'h31);
      step2(1, burst_a[i]);
    end
    step2(0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) expect10(2, 8'hFF);
      step2(1, burst_b[i]);
    end
    step2(0, 8'h00);
    repeat (3) step2(0, 8'h00);

    check("q3_drained", q1.size(), 0);
    check("q10_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
